// File: rtl/rram_wv_ctrl.sv
// Write-verify sequencer for one RRAM word.
// A single read, or a SET/RESET program-and-verify loop bounded by an attempt budget.
// The loop verifies first, then pulses only the cells that failed verify.
//
// Handshake: fsm_go is a single-cycle request that is accepted only in IDLE.
// While busy=1 any fsm_go is dropped. rram_read stays high from the first cycle
// of READ/VERIFY up to and including the cycle in which sa_valid=1 is sampled.
// sa_valid is ignored in every other state. done is a one-cycle strobe that
// closes every accepted request, except one cut short by reset.
module rram_wv_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 48,
  parameter int PW_W   = 8,
  parameter int ATT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fsm_go,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] target_mask,
  input  logic [PW_W-1:0]   pw,
  input  logic [ATT_W-1:0]  max_attempts,
  input  logic              sa_valid,
  input  logic [WORD_W-1:0] sa_data,
  output logic [ADDR_W-1:0] rram_addr,
  output logic              rram_read,
  output logic              rram_set,
  output logic              rram_rst,
  output logic [WORD_W-1:0] rram_mask,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic [ATT_W-1:0]  attempts,
  output logic [WORD_W-1:0] read_data,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_VERIFY = 3'd2,
    S_PULSE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] M_READ  = 2'd0;
  localparam logic [1:0] M_SET   = 2'd1;
  localparam logic [1:0] M_RESET = 2'd2;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] tmask_q, tmask_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic [ATT_W-1:0]  maxa_q, maxa_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic              succ_q, succ_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] pmask_q, pmask_d;
  logic [PW_W-1:0]   pcnt_q, pcnt_d;

  // Cells of the target that already sit in the requested resistance state.
  logic [WORD_W-1:0] pass_word;
  assign pass_word = (mode_q == M_SET) ? (sa_data & tmask_q) : (~sa_data & tmask_q);

  // State and datapath registers; reset clears every output-visible value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      tmask_q <= '0;
      pw_q    <= '0;
      maxa_q  <= '0;
      att_q   <= '0;
      succ_q  <= 1'b0;
      rdata_q <= '0;
      pmask_q <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      tmask_q <= tmask_d;
      pw_q    <= pw_d;
      maxa_q  <= maxa_d;
      att_q   <= att_d;
      succ_q  <= succ_d;
      rdata_q <= rdata_d;
      pmask_q <= pmask_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next-state logic: latch config on go, verify-then-pulse loop, attempt budget.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    tmask_d = tmask_q;
    pw_d    = pw_q;
    maxa_d  = maxa_q;
    att_d   = att_q;
    succ_d  = succ_q;
    rdata_d = rdata_q;
    pmask_d = pmask_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      S_IDLE: begin
        if (fsm_go) begin
          mode_d  = mode;
          addr_d  = addr;
          tmask_d = target_mask;
          pw_d    = pw;
          maxa_d  = max_attempts;
          att_d   = '0;
          succ_d  = 1'b0;
          case (mode)
            M_READ:          state_d = S_READ;
            M_SET, M_RESET:  state_d = S_VERIFY;
            default:         state_d = S_DONE;
          endcase
        end
      end
      S_READ: begin
        if (sa_valid) begin
          rdata_d = sa_data;
          succ_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_VERIFY: begin
        if (sa_valid) begin
          rdata_d = sa_data;
          if (pass_word == tmask_q) begin
            succ_d  = 1'b1;
            state_d = S_DONE;
          end else if (att_q == maxa_q) begin
            succ_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            pmask_d = tmask_q & ~pass_word;
            // A zero pulse width still yields a one-cycle pulse.
            pcnt_d  = (pw_q == '0) ? '0 : pw_q - PW_W'(1);
            att_d   = (&att_q) ? att_q : att_q + ATT_W'(1);
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (pcnt_q == '0) begin
          state_d = S_VERIFY;
        end else begin
          pcnt_d = pcnt_q - PW_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fsm_state = state_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rram_read = (state_q == S_READ) || (state_q == S_VERIFY);
  assign rram_set  = (state_q == S_PULSE) && (mode_q == M_SET);
  assign rram_rst  = (state_q == S_PULSE) && (mode_q == M_RESET);
  assign rram_mask = (state_q == S_PULSE) ? pmask_q : '0;
  assign rram_addr = addr_q;
  assign success   = succ_q;
  assign attempts  = att_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_rram_wv_ctrl.sv
// Bench for rram_wv_ctrl with an 8-cell word: directed cases plus random operations.
// A sense-amp responder replays a planned list of sense words.
// A monitor records every pulse burst.
// A transaction-level model predicts the pulses, attempts, success and read data.
module tb_rram_wv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsm_go = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] addr = '0;
  logic [7:0]  target_mask = '0;
  logic [7:0]  pw = '0;
  logic [7:0]  max_attempts = '0;
  logic        sa_valid = 1'b0;
  logic [7:0]  sa_data = '0;
  logic [15:0] rram_addr;
  logic        rram_read, rram_set, rram_rst, busy, done, success;
  logic [7:0]  rram_mask, attempts, read_data;
  logic [2:0]  fsm_state;

  rram_wv_ctrl #(.ADDR_W(16), .WORD_W(8), .PW_W(8), .ATT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .fsm_go(fsm_go), .mode(mode), .addr(addr),
    .target_mask(target_mask), .pw(pw), .max_attempts(max_attempts),
    .sa_valid(sa_valid), .sa_data(sa_data), .rram_addr(rram_addr),
    .rram_read(rram_read), .rram_set(rram_set), .rram_rst(rram_rst),
    .rram_mask(rram_mask), .busy(busy), .done(done), .success(success),
    .attempts(attempts), .read_data(read_data), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // operation under test and planned sense words
  logic [1:0]  op_mode;
  logic [15:0] op_addr;
  logic [7:0]  op_t, op_pw, op_max;
  logic [7:0]  plan [16];
  int          sense_delay = 1;
  int          sense_cnt = 0;
  int          plan_idx = 0;

  // expectations
  logic [1:0]  exp_kind_q[$];
  logic [7:0]  exp_mask_q[$];
  int          exp_len_q[$];
  logic [7:0]  exp_att, exp_rd;
  logic        exp_succ;
  int          exp_reads;

  // observations
  logic [1:0]  obs_kind_q[$];
  logic [7:0]  obs_mask_q[$];
  int          obs_len_q[$];
  int          read_cycles = 0, done_cnt = 0, bad_cnt = 0, run_len = 0;
  logic [1:0]  run_kind;
  logic [7:0]  run_mask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sense-amp responder: answers a read after sense_delay cycles, noise otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (rram_read) begin
        sense_cnt++;
        if (sense_cnt == sense_delay) begin
          sa_valid = 1'b1;
          sa_data  = plan[plan_idx];
          if (plan_idx < 15) plan_idx++;
        end else begin
          sa_valid = 1'b0;
          sa_data  = 8'($urandom);
        end
      end else begin
        sense_cnt = 0;
        sa_valid  = 1'($urandom_range(0, 1));
        sa_data   = 8'($urandom);
      end
    end
  end

  // Monitor: pulse bursts, read cycles, done strobes, illegal output combinations.
  initial begin
    logic [1:0] kind;
    forever begin
      @(negedge clk);
      if (rram_read) read_cycles++;
      if (done) done_cnt++;
      if (rram_set && rram_rst) bad_cnt++;
      if (!rram_set && !rram_rst && rram_mask != 8'h00) bad_cnt++;
      if (rram_set || rram_rst) begin
        kind = {rram_rst, rram_set};
        if (run_len == 0) begin
          run_kind = kind;
          run_mask = rram_mask;
        end else if (kind != run_kind || rram_mask != run_mask) begin
          bad_cnt++;
        end
        run_len++;
      end else if (run_len > 0) begin
        obs_kind_q.push_back(run_kind);
        obs_mask_q.push_back(run_mask);
        obs_len_q.push_back(run_len);
        run_len = 0;
      end
    end
  end

  // Reference model: walk the planned sense words through the verify/pulse rules.
  task automatic model_op();
    logic [7:0] word, good;
    exp_kind_q.delete(); exp_mask_q.delete(); exp_len_q.delete();
    exp_att = 8'h00; exp_succ = 1'b0; exp_reads = 0;
    if (op_mode == 2'd0) begin
      exp_succ = 1'b1; exp_rd = plan[0]; exp_reads = sense_delay;
    end else if (op_mode != 2'd3) begin
      for (int v = 0; v <= int'(op_max); v++) begin
        word = plan[v];
        exp_rd = word;
        exp_reads += sense_delay;
        good = (op_mode == 2'd1) ? (word & op_t) : (~word & op_t);
        exp_att = 8'(v);
        if (good == op_t) begin exp_succ = 1'b1; break; end
        if (v == int'(op_max)) break;
        exp_kind_q.push_back((op_mode == 2'd1) ? 2'b01 : 2'b10);
        exp_mask_q.push_back(op_t & ~good);
        exp_len_q.push_back((op_pw == 8'h00) ? 1 : int'(op_pw));
      end
    end
  endtask

  task automatic start_op();
    @(negedge clk); #1;
    model_op();
    plan_idx = 0;
    read_cycles = 0; done_cnt = 0; bad_cnt = 0;
    obs_kind_q.delete(); obs_mask_q.delete(); obs_len_q.delete();
    mode = op_mode; addr = op_addr; target_mask = op_t; pw = op_pw; max_attempts = op_max;
    fsm_go = 1'b1;
    @(negedge clk); #1;
    fsm_go = 1'b0;
    check("busy_after_go", busy, 1'b1);
    check("state_after_go", fsm_state,
          (op_mode == 2'd0) ? 3'd1 : (op_mode == 2'd3) ? 3'd4 : 3'd2);
  endtask

  task automatic finish_op();
    int n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk); #1;
    check("done_once", done_cnt, 1);
    check("idle_state", fsm_state, 3'd0);
    check("idle_busy", busy, 1'b0);
    check("success", success, exp_succ);
    check("attempts", attempts, exp_att);
    check("read_data", read_data, exp_rd);
    check("rram_addr", rram_addr, op_addr);
    check("read_cycles", read_cycles, exp_reads);
    check("pulse_count", obs_len_q.size(), exp_len_q.size());
    for (int i = 0; i < exp_len_q.size() && i < obs_len_q.size(); i++) begin
      check("pulse_kind", obs_kind_q[i], exp_kind_q[i]);
      check("pulse_mask", obs_mask_q[i], exp_mask_q[i]);
      check("pulse_len", obs_len_q[i], exp_len_q[i]);
    end
    check("output_rules", bad_cnt, 0);
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!(rram_set || rram_rst) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("pulse_started", rram_set || rram_rst, 1'b1);
  endtask

  initial begin
    int r;
    // reset held with go asserted
    rst_n = 1'b0; fsm_go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", rram_addr, 16'h0);
    check("rst_read", rram_read, 1'b0);
    check("rst_set", rram_set, 1'b0);
    check("rst_rst", rram_rst, 1'b0);
    check("rst_mask", rram_mask, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_success", success, 1'b0);
    check("rst_attempts", attempts, 8'h00);
    check("rst_read_data", read_data, 8'h00);
    check("rst_state", fsm_state, 3'd0);
    @(negedge clk);
    fsm_go = 1'b0; rst_n = 1'b1;
    exp_rd = 8'h00;

    // READ with a 4-cycle sense latency
    op_mode = 2'd0; op_addr = 16'h1234; op_t = 8'h00; op_pw = 8'd0; op_max = 8'd0;
    sense_delay = 4; plan[0] = 8'hA5;
    start_op(); finish_op();

    // minimum-latency READ
    op_addr = 16'h0042; sense_delay = 1; plan[0] = 8'h3C;
    start_op();
    @(negedge clk); #1;
    check("minlat_done_state", fsm_state, 3'd4);
    finish_op();

    // SET converging after two pulses
    op_mode = 2'd1; op_addr = 16'h0101; op_t = 8'hFF; op_pw = 8'd3; op_max = 8'd5;
    sense_delay = 2; plan[0] = 8'h0F; plan[1] = 8'h3F; plan[2] = 8'hFF;
    start_op(); finish_op();

    // RESET exhausting the attempt budget with zero pulse width
    op_mode = 2'd2; op_addr = 16'h0202; op_t = 8'h01; op_pw = 8'd0; op_max = 8'd3;
    for (int i = 0; i < 16; i++) plan[i] = 8'h01;
    start_op(); finish_op();

    // already programmed word
    op_mode = 2'd1; op_addr = 16'h0303; op_t = 8'hFF; op_pw = 8'd2; op_max = 8'd4;
    plan[0] = 8'hFF;
    start_op(); finish_op();

    // illegal mode
    op_mode = 2'd3; op_addr = 16'h0404;
    start_op(); finish_op();

    // empty target mask and verify-only budget
    op_mode = 2'd2; op_addr = 16'h0505; op_t = 8'h00; plan[0] = 8'hFF;
    start_op(); finish_op();
    op_mode = 2'd1; op_t = 8'hFF; op_max = 8'd0; plan[0] = 8'h00;
    start_op(); finish_op();

    // go during PULSE is ignored
    op_mode = 2'd1; op_addr = 16'hBEEF; op_t = 8'hF0; op_pw = 8'd4; op_max = 8'd3;
    plan[0] = 8'h00; plan[1] = 8'hF0;
    start_op();
    wait_pulse();
    mode = 2'd2; addr = 16'h5555; target_mask = 8'h0F; pw = 8'd1; max_attempts = 8'd0;
    fsm_go = 1'b1;
    @(negedge clk); #1;
    fsm_go = 1'b0;
    check("ignored_go_addr", rram_addr, 16'hBEEF);
    check("ignored_go_mask", rram_mask, 8'hF0);
    finish_op();

    // reset in the middle of a pulse
    op_mode = 2'd1; op_addr = 16'h7777; op_t = 8'hFF; op_pw = 8'd10; op_max = 8'd2;
    plan[0] = 8'h00;
    start_op();
    wait_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_set", rram_set, 1'b0);
    check("midrst_mask", rram_mask, 8'h00);
    check("midrst_state", fsm_state, 3'd0);
    check("midrst_attempts", attempts, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", fsm_state, 3'd0);
    exp_rd = 8'h00;

    // random operations
    for (int k = 0; k < 40; k++) begin
      op_mode = 2'($urandom_range(0, 3));
      op_addr = 16'($urandom);
      r = $urandom_range(0, 9);
      op_t = (r < 2) ? 8'h00 : (r < 4) ? 8'hFF : 8'($urandom);
      op_pw = 8'($urandom_range(0, 4));
      op_max = 8'($urandom_range(0, 4));
      sense_delay = $urandom_range(1, 3);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) plan[i] = (op_mode == 2'd1) ? 8'hFF : 8'h00;
        else plan[i] = 8'($urandom);
      end
      start_op(); finish_op();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
